// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: a one-word holding buffer feeds a shift register
// so words stream gaplessly onto seq_out; seq_out rests at IDLE_BIT between words.
module seq_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             seq_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int unsigned      CNT_W      = $clog2(WIDTH);
    localparam logic [0:0]       ST_IDLE    = 1'b0;
    localparam logic [0:0]       ST_SHIFT   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    logic [WIDTH-1:0] hold_r;
    logic             hold_full_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic [0:0]       state_r;
    logic             free_s;
    logic             accept_s;
    logic             transfer_s;

    // Bit that leaves the word first, according to the configured bit order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) first_bit = w[WIDTH-1];
        else           first_bit = w[0];
    endfunction

    // Drop the bit just sent so the next one sits in the first_bit position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) advance = {w[WIDTH-2:0], 1'b0};
        else           advance = {1'b0, w[WIDTH-1:1]};
    endfunction

    // Shifter can take a new word when idle or while its final bit is on the wire.
    always_comb begin
        free_s = 1'b1;
        case (state_r)
            ST_IDLE:  free_s = 1'b1;
            ST_SHIFT: free_s = (cnt_r == CNT_LAST);
            default:  free_s = 1'b1;
        endcase
    end

    // Accept needs an empty buffer and transfer a full one, so they never coincide.
    assign accept_s   = data_valid && !hold_full_r;
    assign transfer_s = free_s && hold_full_r;
    assign data_ready = !hold_full_r;
    assign busy       = bit_valid || hold_full_r;

    // Holding buffer: filled on handshake, emptied when the shifter takes the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_r      <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
        end else if (accept_s) begin
            hold_r      <= data_in;
            hold_full_r <= 1'b1;
        end else if (transfer_s) begin
            hold_full_r <= 1'b0;
        end
    end

    // Shift register and serial outputs; shreg_r holds the bits not yet sent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r   <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= ST_IDLE;
            seq_out   <= IDLE_BIT;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
        end else if (transfer_s) begin
            shreg_r   <= advance(hold_r);
            seq_out   <= first_bit(hold_r);
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= ST_SHIFT;
            bit_valid <= 1'b1;
            last_bit  <= 1'b0;
        end else if (free_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= ST_IDLE;
            seq_out   <= IDLE_BIT;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
        end else begin
            shreg_r   <= advance(shreg_r);
            seq_out   <= first_bit(shreg_r);
            cnt_r     <= cnt_r + CNT_W'(1);
            last_bit  <= (cnt_r == CNT_PENULT);
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: two instances (MSB-first/idle 0, LSB-first/idle 1) share
// stimulus and are compared every cycle against a queue-based model of the bit stream.
module tb_seq_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;

    logic ready_a, seq_a, bv_a, last_a, busy_a;
    logic ready_b, seq_b, bv_b, last_b, busy_b;

    int checks = 0;
    int errors = 0;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_a), .seq_out(seq_a), .bit_valid(bv_a), .last_bit(last_a), .busy(busy_a)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_b), .seq_out(seq_b), .bit_valid(bv_b), .last_bit(last_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pending bits of the word on the wire live in a queue; hold is one slot.
    bit         q_a[$];
    bit         q_b[$];
    logic [7:0] m_hold   = 8'h00;
    logic       m_full   = 1'b0;
    logic       acc_evt  = 1'b0;
    logic       e_seq_a  = 1'b0;
    logic       e_seq_b  = 1'b1;
    logic       e_bv     = 1'b0;
    logic       e_last   = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q_a.delete();
            q_b.delete();
            m_full  = 1'b0;
            acc_evt = 1'b0;
            e_seq_a = 1'b0;
            e_seq_b = 1'b1;
            e_bv    = 1'b0;
            e_last  = 1'b0;
        end else begin
            acc_evt = data_valid && !m_full;
            if (q_a.size() == 0) begin
                if (m_full) begin
                    for (int i = 0; i < 8; i++) begin
                        q_a.push_back(m_hold[7-i]);
                        q_b.push_back(m_hold[i]);
                    end
                    m_full  = 1'b0;
                    e_seq_a = q_a.pop_front();
                    e_seq_b = q_b.pop_front();
                    e_bv    = 1'b1;
                    e_last  = (q_a.size() == 0);
                end else begin
                    e_seq_a = 1'b0;
                    e_seq_b = 1'b1;
                    e_bv    = 1'b0;
                    e_last  = 1'b0;
                end
            end else begin
                e_seq_a = q_a.pop_front();
                e_seq_b = q_b.pop_front();
                e_bv    = 1'b1;
                e_last  = (q_a.size() == 0);
            end
            if (acc_evt) begin
                m_hold = data_in;
                m_full = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Capture of the MSB-first/LSB-first streams for the literal scenario checks.
    logic [31:0] cap_a, cap_b, cap_l;
    int          cap_n, run, max_run, ready_falls;
    logic        prev_ready;

    task automatic clear_cap();
        cap_a = 32'h0; cap_b = 32'h0; cap_l = 32'h0;
        cap_n = 0; run = 0; max_run = 0; ready_falls = 0;
    endtask

    always @(negedge clk) begin
        chk("seq_a", {31'h0, seq_a}, {31'h0, e_seq_a});
        chk("seq_b", {31'h0, seq_b}, {31'h0, e_seq_b});
        chk("bit_valid_a", {31'h0, bv_a}, {31'h0, e_bv});
        chk("bit_valid_b", {31'h0, bv_b}, {31'h0, e_bv});
        chk("last_bit_a", {31'h0, last_a}, {31'h0, e_last});
        chk("last_bit_b", {31'h0, last_b}, {31'h0, e_last});
        chk("data_ready_a", {31'h0, ready_a}, {31'h0, !m_full});
        chk("data_ready_b", {31'h0, ready_b}, {31'h0, !m_full});
        chk("busy_a", {31'h0, busy_a}, {31'h0, e_bv || m_full});
        chk("busy_b", {31'h0, busy_b}, {31'h0, e_bv || m_full});
        if (!reset) begin
            if (bv_a) begin
                cap_a = {cap_a[30:0], seq_a};
                cap_b = {cap_b[30:0], seq_b};
                cap_l = {cap_l[30:0], last_a};
                cap_n++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (prev_ready && !ready_a) ready_falls++;
        end
        prev_ready = ready_a;
    end

    task automatic offer(input logic [7:0] w);
        int n;
        n = 0;
        data_valid = 1'b1;
        data_in    = w;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!acc_evt && n < 50);
        checks++;
        if (!acc_evt) begin
            errors++;
            $display("FAIL offer_timeout: word %0h not accepted in %0d cycles", w, n);
        end
        data_valid = 1'b0;
        data_in    = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((e_bv || m_full) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (e_bv || m_full) begin
            errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles", n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_seq_a"}, {31'h0, seq_a}, 32'h0);
        chk({tag, "_seq_b"}, {31'h0, seq_b}, 32'h1);
        chk({tag, "_bv"}, {30'h0, bv_a, bv_b}, 32'h0);
        chk({tag, "_last"}, {30'h0, last_a, last_b}, 32'h0);
        chk({tag, "_ready"}, {30'h0, ready_a, ready_b}, 32'h3);
        chk({tag, "_busy"}, {30'h0, busy_a, busy_b}, 32'h0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_pulse");
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        prev_ready = 1'b1;
        clear_cap();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single word B4, with junk on data_in while valid is low.
        clear_cap();
        offer(8'hB4);
        wait_idle();
        chk("b4_count", cap_n, 32'd8);
        chk("b4_msb_stream", cap_a, 32'h0000_00B4);
        chk("b4_lsb_stream", cap_b, 32'h0000_002D);
        chk("b4_last_pos", cap_l, 32'h0000_0001);
        chk("idle_level", {30'h0, seq_a, seq_b}, 32'h1);

        // LSB-first ordering of 0D is 1,0,1,1,0,0,0,0.
        clear_cap();
        offer(8'h0D);
        wait_idle();
        chk("0d_lsb_stream", cap_b, 32'h0000_00B0);
        chk("0d_msb_stream", cap_a, 32'h0000_000D);

        // Back-to-back words must stream with no idle gap.
        clear_cap();
        offer(8'hB0);
        offer(8'hD0);
        wait_idle();
        chk("b2b_count", cap_n, 32'd16);
        chk("b2b_stream", cap_a, 32'h0000_B0D0);
        chk("b2b_run", max_run, 32'd16);
        chk("b2b_last_pos", cap_l, 32'h0000_0101);

        // Backpressure: valid held high for three words.
        clear_cap();
        offer(8'hA5);
        offer(8'h3C);
        offer(8'h96);
        wait_idle();
        chk("bp_count", cap_n, 32'd24);
        chk("bp_stream", cap_a, 32'h00A5_3C96);
        chk("bp_run", max_run, 32'd24);
        chk("bp_ready_falls", ready_falls, 32'd3);

        // Reset after three bits of FF with the holding buffer full.
        offer(8'hFF);
        offer(8'hAA);
        @(posedge clk); #1;
        chk("pre_reset_busy", {31'h0, busy_a}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("midword");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_cap();
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_quiet", cap_n, 32'd0);
        offer(8'h0F);
        wait_idle();
        chk("0f_count", cap_n, 32'd8);
        chk("0f_stream", cap_a, 32'h0000_000F);

        // Randomized traffic with gaps, continuous runs and occasional resets.
        for (int k = 0; k < 300; k++) begin
            int gap;
            gap = ($urandom_range(0, 9) < 5) ? 0 : $urandom_range(1, 12);
            repeat (gap) begin
                data_in = 8'($urandom);
                @(posedge clk); #1;
            end
            if (k % 97 == 50) pulse_reset();
            offer(8'($urandom));
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
